// File: rtl/fifo_sched_pkg.sv
// Shared scheduler types and the wrap-around search helper
// used by fifo read-side (and future write-side) arbiters.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam int MAX_CH = 32;

  // First set bit strictly after last, wrapping modulo n.
  // last itself is visited last. Returns last when mask is 0.
  function automatic int rr_next(
    input logic [MAX_CH-1:0] mask,
    input int                last,
    input int                n
  );
    int r;
    r = last;
    for (int k = n; k >= 1; k--) begin
      if (mask[(last + k) % n]) r = (last + k) % n;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the next set bit
// of mask after last (wrapping). Ports: mask, last -> found, idx.
module rr_pick
  import fifo_sched_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CW-1:0]     last,
  output logic              found,
  output logic [CW-1:0]     idx
);

  logic [MAX_CH-1:0] m;

  always_comb begin
    m     = MAX_CH'(mask);
    found = |mask;
    idx   = CW'(rr_next(m, int'(last), NUM_CH));
  end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NUM_CH fifos into one valid/ready sink.
// Ports: ch_en/fifo_empty/fifo_data in, fifo_ren out, out_* handshake, busy.
module fifo_rr_drain
  import fifo_sched_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int DW        = 8,
  parameter  int MAX_BURST = 2,
  localparam int CW        = $clog2(NUM_CH),
  localparam int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic [NUM_CH-1:0]    fifo_empty,
  input  logic [NUM_CH*DW-1:0] fifo_data,
  output logic [NUM_CH-1:0]    fifo_ren,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [CW-1:0]        out_ch,
  output logic                 busy
);

  localparam logic [BW:0] MB = (BW+1)'(MAX_BURST);

  state_t            state;
  logic [CW-1:0]     grant;
  logic [CW-1:0]     last_grant;
  logic [BW-1:0]     burst_cnt;
  logic [BW:0]       cnt_nx;
  logic [NUM_CH-1:0] elig;
  logic              pick_found;
  logic [CW-1:0]     pick_idx;
  logic [DW-1:0]     ch_data [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slice
    assign ch_data[i] = fifo_data[i*DW +: DW];
  end

  assign elig   = ch_en & ~fifo_empty;
  assign cnt_nx = {1'b0, burst_cnt} + (BW+1)'(1);

  rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .mask  (elig),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign out_valid = (state == PRESENT);
  assign busy      = (state != IDLE);

  // Read strobe is a pure decode of READ, so it can
  // never overlap a held word in PRESENT.
  always_comb begin
    fifo_ren = '0;
    if (state == READ) fifo_ren[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CW'(NUM_CH - 1);
      burst_cnt  <= '0;
      out_data   <= '0;
      out_ch     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant     <= pick_idx;
            burst_cnt <= '0;
            state     <= READ;
          end
        end
        READ: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          // fifo registered data_out on the READ edge
          out_data <= ch_data[grant];
          out_ch   <= grant;
          state    <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            burst_cnt <= cnt_nx[BW-1:0];
            if (cnt_nx < MB && elig[grant]) begin
              state <= READ;
            end else begin
              last_grant <= grant;
              state      <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
